mir_decoder: RTL

- Downstream stage of the microcoded control store.
- Captures each 30-bit microinstruction word the control store issues, decodes its fields into one-cycle register-load strobes, a held bus-source select and a held ALU opcode.
- Sequences the memory handshake (read/write) that a microinstruction requests, stalling until the memory acknowledges or times out.
- Feeds the datapath register file, the ALU and the memory interface.

---
 rtl/mir_decoder_if.sv | 33 +++
 rtl/mir_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mir_decoder_if.sv
// Signal bundle between the control store / memory side and the microinstruction decoder.
// The decoder connects through the slave modport; the control store and memory connect through master.
interface mir_decoder_if #(
    parameter int MIR_W = 30,
    parameter int NLD   = 10
);
    logic [MIR_W-1:0] mir;
    logic             mir_valid;
    logic             mem_ack;
    logic [NLD-1:0]   ld_en;
    logic [3:0]       bus_sel;
    logic [3:0]       alu_op;
    logic             pc_inc;
    logic             mem_req;
    logic             mem_we;
    logic             mem_fetch;
    logic             mbr_ld;
    logic             busy;
    logic             mem_err;
    logic             overrun;

    modport master (
        output mir, mir_valid, mem_ack,
        input  ld_en, bus_sel, alu_op, pc_inc, mem_req, mem_we, mem_fetch,
               mbr_ld, busy, mem_err, overrun
    );

    modport slave (
        input  mir, mir_valid, mem_ack,
        output ld_en, bus_sel, alu_op, pc_inc, mem_req, mem_we, mem_fetch,
               mbr_ld, busy, mem_err, overrun
    );
endinterface

// File: rtl/mir_decoder.sv
// Microinstruction register and decoder: captures control-store words, issues register-load
// strobes, and sequences memory read/write handshakes with a bounded acknowledge wait.
module mir_decoder #(
    parameter int MIR_W = 30,
    parameter int NLD   = 10,
    parameter int TMO   = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mir_decoder_if.slave  bus
);
    // Only the low fields are kept; the next-address field belongs to the sequencer.
    localparam int CAP_W = NLD + 12;
    localparam int CW    = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM_WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CAP_W-1:0] cap;
    logic [CW-1:0]    wait_cnt;
    logic             mem_req_q;
    logic             mem_we_q;
    logic             mem_fetch_q;
    logic             mem_err_q;
    logic             overrun_q;

    logic [2:0]       mem_field;
    logic [NLD-1:0]   cap_ld;
    logic             cap_pc;
    logic             cap_write;

    logic             req_start;
    logic             req_stop;
    logic             err_set;
    logic             cnt_inc;
    logic [NLD-1:0]   ld_en_c;
    logic             pc_inc_c;
    logic             mbr_ld_c;

    assign mem_field = cap[7:5];
    assign cap_pc    = cap[4];
    assign cap_ld    = cap[8 +: NLD];
    assign cap_write = cap[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_start  = 1'b0;
        req_stop   = 1'b0;
        err_set    = 1'b0;
        cnt_inc    = 1'b0;
        ld_en_c    = '0;
        pc_inc_c   = 1'b0;
        mbr_ld_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mir_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (mem_field == 3'b000) begin
                    ld_en_c    = cap_ld;
                    pc_inc_c   = cap_pc;
                    state_next = IDLE;
                end else if ($onehot(mem_field)) begin
                    req_start  = 1'b1;
                    state_next = MEM_WAIT;
                end else begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            MEM_WAIT: begin
                // An acknowledge on the final wait cycle still completes the access.
                if (bus.mem_ack) begin
                    req_stop   = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    req_stop   = 1'b1;
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                ld_en_c    = cap_ld;
                pc_inc_c   = cap_pc;
                mbr_ld_c   = !cap_write;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap         <= '0;
            wait_cnt    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_fetch_q <= 1'b0;
            mem_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.mir_valid) begin
                cap <= bus.mir[CAP_W-1:0];
            end
            // Words arriving while busy, including the last busy cycle, are dropped.
            if (state != IDLE && bus.mir_valid) begin
                overrun_q <= 1'b1;
            end
            if (err_set) begin
                mem_err_q <= 1'b1;
            end
            if (req_start) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (req_start) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= (mem_field == 3'b001);
                mem_fetch_q <= (mem_field == 3'b100);
            end else if (req_stop) begin
                mem_req_q   <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_fetch_q <= 1'b0;
            end
        end
    end

    assign bus.ld_en     = ld_en_c;
    assign bus.pc_inc    = pc_inc_c;
    assign bus.mbr_ld    = mbr_ld_c;
    assign bus.bus_sel   = cap[3:0];
    assign bus.alu_op    = cap[CAP_W-1 -: 4];
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_fetch = mem_fetch_q;
    assign bus.busy      = (state != IDLE);
    assign bus.mem_err   = mem_err_q;
    assign bus.overrun   = overrun_q;
endmodule
